reg_file_wb: RTL and testbench



---
 rtl/reg_file_wb_pkg.sv | 20 ++
 rtl/reg_file_wb_read_port.sv | 36 +++
 rtl/reg_file_wb.sv | 99 +++++++++
 tb/tb_reg_file_wb.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/reg_file_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_wb_pkg
// Description : Register indices and reset defaults shared by the register
//               file and the memory map.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_wb_pkg;

    localparam int          REG_COUNT = 32;
    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [4:0]  REG_GP    = 5'd28;
    localparam logic [4:0]  REG_SP    = 5'd29;
    localparam logic [4:0]  REG_RA    = 5'd31;

    localparam logic [31:0] SP_INIT_DEFAULT = 32'h0000_2ffc;
    localparam logic [31:0] GP_INIT_DEFAULT = 32'h0000_1800;

endpackage
`default_nettype wire

// File: rtl/reg_file_wb_read_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_port
// Description : One combinational register-file read port with $0 forcing
//               and optional same-cycle write forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_read_port
    import reg_file_wb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic [4:0]                      idx,
    input  logic [REG_COUNT-1:0][WIDTH-1:0] regs,
    input  logic                            wr_en,
    input  logic [4:0]                      wr_idx,
    input  logic [WIDTH-1:0]                wr_data,
    output logic [WIDTH-1:0]                data
);

    logic w_hit;

    always_comb begin
        w_hit = (BYPASS != 0) && wr_en && (wr_idx == idx);
        data  = regs[idx];
        // $0 wins over forwarding so a write aimed at $0 can never leak out
        if (idx == REG_ZERO) begin
            data = '0;
        end else if (w_hit) begin
            data = wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_wb
// Description : 32x32 MIPS register file, write-back side, two async reads.
//               Define REGFILE_DBG_EN for the debug read port, write counter
//               and simulation write trace.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               BYPASS  = 1,
    parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(SP_INIT_DEFAULT),
    parameter logic [WIDTH-1:0] GP_INIT = WIDTH'(GP_INIT_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ra,
    input  logic [4:0]       rb,
    output logic [WIDTH-1:0] busA,
    output logic [WIDTH-1:0] busB,
    input  logic             RegWr,
    input  logic [4:0]       rw,
    input  logic [WIDTH-1:0] busW
`ifdef REGFILE_DBG_EN
    ,
    input  logic [4:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [31:0]      wr_count
`endif
);

    logic [REG_COUNT-1:0][WIDTH-1:0] r_regs;
    logic                            w_wr_en;
    logic                            w_accept;

    // Reset suppresses forwarding too, so reads show reset contents at once
    assign w_wr_en  = RegWr && !rst;
    assign w_accept = w_wr_en && (rw != REG_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[REG_GP] <= GP_INIT;
            r_regs[REG_SP] <= SP_INIT;
        end else if (w_accept) begin
            r_regs[rw] <= busW;
        end
    end

    reg_read_port #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_port_a (
        .idx     (ra),
        .regs    (r_regs),
        .wr_en   (w_wr_en),
        .wr_idx  (rw),
        .wr_data (busW),
        .data    (busA)
    );

    reg_read_port #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_port_b (
        .idx     (rb),
        .regs    (r_regs),
        .wr_en   (w_wr_en),
        .wr_idx  (rw),
        .wr_data (busW),
        .data    (busB)
    );

`ifdef REGFILE_DBG_EN
    logic [31:0] r_wr_count;

    reg_read_port #(.WIDTH(WIDTH), .BYPASS(0)) u_port_dbg (
        .idx     (dbg_addr),
        .regs    (r_regs),
        .wr_en   (1'b0),
        .wr_idx  (REG_ZERO),
        .wr_data ('0),
        .data    (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_count <= '0;
        end else if (w_accept) begin
            r_wr_count <= r_wr_count + 32'd1;
`ifndef SYNTHESIS
            $display("R%0d <= %h", rw, busW);
`endif
        end
    end

    assign wr_count = r_wr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_wb
// Description : Directed vector bench for reg_file_wb, forwarding and
//               non-forwarding builds side by side on shared inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra, rb, rw;
    logic        RegWr;
    logic [31:0] busW;
    logic [31:0] busA1, busB1, busA0, busB0;
    int          n_checks = 0;
    int          n_pass   = 0;

`ifdef REGFILE_DBG_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data1, dbg_data0, wr_count1, wr_count0;
`endif

    always #5 clk = ~clk;

    reg_file_wb #(.BYPASS(1)) u_dut_byp (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb), .busA(busA1), .busB(busB1),
        .RegWr(RegWr), .rw(rw), .busW(busW)
`ifdef REGFILE_DBG_EN
        , .dbg_addr(dbg_addr), .dbg_data(dbg_data1), .wr_count(wr_count1)
`endif
    );

    reg_file_wb #(.BYPASS(0)) u_dut_nob (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb), .busA(busA0), .busB(busB0),
        .RegWr(RegWr), .rw(rw), .busW(busW)
`ifdef REGFILE_DBG_EN
        , .dbg_addr(dbg_addr), .dbg_data(dbg_data0), .wr_count(wr_count0)
`endif
    );

    typedef struct {
        logic        wr;
        logic [4:0]  rw;
        logic [31:0] w;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a_byp;
        logic [31:0] exp_b_byp;
        logic [31:0] exp_a_nob;
        logic [31:0] exp_b_nob;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        // Expected values are the pre-edge reads; each write lands at the edge after.
        vecs[0] = '{1'b1, 5'd8,  32'hdead_beef, 5'd8,  5'd9,  32'hdead_beef, 32'h0,         32'h0,         32'h0};
        vecs[1] = '{1'b0, 5'd8,  32'h0,         5'd8,  5'd9,  32'hdead_beef, 32'h0,         32'hdead_beef, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'hffff_ffff, 5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'hffff_ffff, 5'd0,  5'd29, 32'h0,         32'h0000_2ffc, 32'h0,         32'h0000_2ffc};
        vecs[4] = '{1'b1, 5'd31, 32'h0040_0008, 5'd31, 5'd31, 32'h0040_0008, 32'h0040_0008, 32'h0,         32'h0};
        vecs[5] = '{1'b0, 5'd31, 32'h0,         5'd31, 5'd31, 32'h0040_0008, 32'h0040_0008, 32'h0040_0008, 32'h0040_0008};
        vecs[6] = '{1'b1, 5'd28, 32'h0000_aaaa, 5'd28, 5'd8,  32'h0000_aaaa, 32'hdead_beef, 32'h0000_1800, 32'hdead_beef};
        vecs[7] = '{1'b1, 5'd5,  32'h0000_0055, 5'd28, 5'd5,  32'h0000_aaaa, 32'h0000_0055, 32'h0000_aaaa, 32'h0};
        vecs[8] = '{1'b0, 5'd5,  32'h0000_0077, 5'd5,  5'd5,  32'h0000_0055, 32'h0000_0055, 32'h0000_0055, 32'h0000_0055};

        rst = 1'b0; RegWr = 1'b0; rw = '0; busW = '0; ra = 5'd29; rb = 5'd28;
`ifdef REGFILE_DBG_EN
        dbg_addr = 5'd29;
`endif
        // Reset asserted between edges must be visible immediately
        #3 rst = 1'b1;
        #1;
        chk("reset_sp_byp", busA1, 32'h0000_2ffc);
        chk("reset_gp_byp", busB1, 32'h0000_1800);
        chk("reset_sp_nob", busA0, 32'h0000_2ffc);
        chk("reset_gp_nob", busB0, 32'h0000_1800);
        ra = 5'd5;
        #1;
        chk("reset_r5", busA1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            RegWr = vecs[i].wr; rw = vecs[i].rw; busW = vecs[i].w;
            ra = vecs[i].ra; rb = vecs[i].rb;
            #1;
            chk($sformatf("vec%0d_a_byp", i), busA1, vecs[i].exp_a_byp);
            chk($sformatf("vec%0d_b_byp", i), busB1, vecs[i].exp_b_byp);
            chk($sformatf("vec%0d_a_nob", i), busA0, vecs[i].exp_a_nob);
            chk($sformatf("vec%0d_b_nob", i), busB0, vecs[i].exp_b_nob);
        end

        @(negedge clk);
        RegWr = 1'b0;
        ra = 5'd0; rb = 5'd5;
        #1;
        chk("r0_after_write", busA1, 32'h0);
        chk("r5_final", busB0, 32'h0000_0055);
`ifdef REGFILE_DBG_EN
        chk("wr_count_byp", wr_count1, 32'd4);
        chk("wr_count_nob", wr_count0, 32'd4);
        dbg_addr = 5'd28;
        #1;
        chk("dbg_r28", dbg_data1, 32'h0000_aaaa);
        dbg_addr = 5'd0;
        #1;
        chk("dbg_r0", dbg_data1, 32'h0);
`endif

        // Reset coincident with a write: the write is discarded
        @(negedge clk);
        RegWr = 1'b1; rw = 5'd10; busW = 32'h0000_1234; ra = 5'd10; rb = 5'd8;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; RegWr = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_r10_byp", busA1, 32'h0);
        chk("midrst_r10_nob", busA0, 32'h0);
        chk("midrst_r8", busB1, 32'h0);
        ra = 5'd29; rb = 5'd31;
        #1;
        chk("midrst_sp", busA1, 32'h0000_2ffc);
        chk("midrst_r31", busB1, 32'h0);
`ifdef REGFILE_DBG_EN
        chk("midrst_wr_count", wr_count1, 32'd0);
        dbg_addr = 5'd29;
        #1;
        chk("dbg_sp", dbg_data1, 32'h0000_2ffc);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
